// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the parametrised synchronous FIFO: pointer width and read-mode constants.
package sync_fifo_pkg;

    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    // One extra pointer bit distinguishes full from empty when the indices match.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: register array with one synchronous write port and one asynchronous read port.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]      rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Contents are intentionally left unreset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with thresholds, occupancy count, sticky error flags, flush and optional FWFT read.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = MODE_STD
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         w_en,
    input  logic                         r_en,
    input  logic [DATA_WIDTH-1:0]        data_in,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [ptr_w(DEPTH)-1:0]      count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of 2 and at least 4");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("sync_fifo_param: AF_THRESH out of range 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_param: AE_THRESH out of range 0..DEPTH-1");
    end
    if (FWFT != MODE_STD && FWFT != MODE_FWFT) begin : g_bad_mode
        $error("sync_fifo_param: FWFT must be 0 or 1");
    end

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flags decode straight from the registered pointers, so they track the last edge.
    assign count        = wr_ptr_q - rd_ptr_q;
    assign full         = (count == PW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= PW'(AF_THRESH));
    assign almost_empty = (count <= PW'(AE_THRESH));
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    assign wr_acc = w_en && !full  && !clr;
    assign rd_acc = r_en && !empty && !clr;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        dout_d   = dout_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
            dout_d   = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
            if (w_en && full)  ovf_d = 1'b1;
            if (r_en && empty) udf_d = 1'b1;
            if (rd_acc) dout_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            dout_q   <= dout_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (data_in),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (mem_rdata)
    );

    assign data_out = (FWFT == MODE_FWFT) ? mem_rdata : dout_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: vector table for fill/drain, hand sequences for corner cases.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       w_en = 1'b0;
    logic       r_en = 1'b0;
    logic [7:0] data_in = '0;

    logic [7:0] s_dout, f_dout;
    logic       s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [4:0] s_count, f_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .clr(clr), .w_en(w_en), .r_en(r_en),
        .data_in(data_in), .data_out(s_dout), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_udf)
    );

    sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1)) u_fw (
        .clk(clk), .rst_n(rst_n), .clr(clr), .w_en(w_en), .r_en(r_en),
        .data_in(data_in), .data_out(f_dout), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_udf)
    );

    typedef struct {
        logic       clr, w, r;
        logic [7:0] din;
        logic [4:0] cnt;
        logic       full, empty, af, ae, ovf, udf;
        logic [7:0] dout;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic c, input logic w, input logic r, input logic [7:0] d);
        @(negedge clk);
        clr = c; w_en = w; r_en = r; data_in = d;
        @(posedge clk);
        #1;
        clr = 1'b0; w_en = 1'b0; r_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] sb[$];
        logic [7:0] d;
        logic [7:0] e;
        int c;

        // Fill to full, one dropped write, drain in order, then flush.
        for (int i = 0; i < 16; i++) begin
            c = i + 1;
            vecs.push_back('{1'b0, 1'b1, 1'b0, 8'(i + 1), 5'(c), (c == 16), 1'b0,
                             (c >= 14), (c <= 2), 1'b0, 1'b0, 8'h00});
        end
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'hFF, 5'd16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00});
        for (int j = 0; j < 16; j++) begin
            c = 15 - j;
            vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 5'(c), 1'b0, (c == 0),
                             (c >= 14), (c <= 2), 1'b1, 1'b0, 8'(j + 1)});
        end
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});

        repeat (2) @(posedge clk);
        #1;
        chk("rst.count", s_count, 0);
        chk("rst.empty", s_empty, 1);
        chk("rst.ae", s_ae, 1);
        chk("rst.full", s_full, 0);
        chk("rst.af", s_af, 0);
        chk("rst.ovf", s_ovf, 0);
        chk("rst.udf", s_udf, 0);
        chk("rst.dout", s_dout, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            step(vecs[k].clr, vecs[k].w, vecs[k].r, vecs[k].din);
            chk($sformatf("vec%0d.count", k), s_count, vecs[k].cnt);
            chk($sformatf("vec%0d.full", k), s_full, vecs[k].full);
            chk($sformatf("vec%0d.empty", k), s_empty, vecs[k].empty);
            chk($sformatf("vec%0d.af", k), s_af, vecs[k].af);
            chk($sformatf("vec%0d.ae", k), s_ae, vecs[k].ae);
            chk($sformatf("vec%0d.ovf", k), s_ovf, vecs[k].ovf);
            chk($sformatf("vec%0d.udf", k), s_udf, vecs[k].udf);
            chk($sformatf("vec%0d.dout", k), s_dout, vecs[k].dout);
        end

        // Alternating write/read with random data; 40 words wrap the pointers twice.
        for (int k = 0; k < 40; k++) begin
            d = 8'($urandom);
            step(1'b0, 1'b1, 1'b0, d);
            sb.push_back(d);
            chk($sformatf("alt%0d.count_w", k), s_count, 1);
            step(1'b0, 1'b0, 1'b1, 8'h00);
            e = sb.pop_front();
            chk($sformatf("alt%0d.dout", k), s_dout, e);
            chk($sformatf("alt%0d.count_r", k), s_count, 0);
        end

        // Full FIFO with simultaneous write and read: read wins, write dropped.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 8'(8'hB0 + i));
        chk("full_wr.count_before", s_count, 16);
        step(1'b0, 1'b1, 1'b1, 8'hEE);
        chk("full_wr.count", s_count, 15);
        chk("full_wr.ovf", s_ovf, 1);
        chk("full_wr.dout", s_dout, 8'hB0);
        chk("full_wr.full", s_full, 0);
        for (int i = 1; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            chk($sformatf("full_drain%0d.dout", i), s_dout, 8'(8'hB0 + i));
        end
        chk("full_drain.empty", s_empty, 1);

        // Empty FIFO with simultaneous write and read: write wins, underflow set.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'hA5);
        chk("empty_wr.count", s_count, 1);
        chk("empty_wr.udf", s_udf, 1);
        chk("empty_wr.ovf", s_ovf, 0);
        chk("empty_wr.dout", s_dout, 0);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("empty_wr.read_dout", s_dout, 8'hA5);
        chk("empty_wr.read_count", s_count, 0);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("rej_read.dout_hold", s_dout, 8'hA5);
        chk("rej_read.count", s_count, 0);

        // First-word-fall-through instance.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h3C);
        chk("fwft.first", f_dout, 8'h3C);
        chk("fwft.empty", f_empty, 0);
        chk("std.no_fall_through", s_dout, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h4D);
        chk("fwft.head_hold", f_dout, 8'h3C);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("fwft.second", f_dout, 8'h4D);
        chk("fwft.count", f_count, 1);
        chk("std.pop_dout", s_dout, 8'h3C);

        // Flush with both sticky flags set and a concurrent write.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("clr_pre.count", s_count, 10);
        chk("clr_pre.ovf", s_ovf, 1);
        chk("clr_pre.udf", s_udf, 1);
        step(1'b1, 1'b1, 1'b0, 8'h77);
        chk("clr.count", s_count, 0);
        chk("clr.empty", s_empty, 1);
        chk("clr.ovf", s_ovf, 0);
        chk("clr.udf", s_udf, 0);
        chk("clr.dout", s_dout, 0);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("clr.no_write", s_count, 0);

        // Asynchronous reset between edges with 7 words held.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("arst_pre.count", s_count, 7);
        chk("arst_pre.dout", s_dout, 8'h60);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.count", s_count, 0);
        chk("arst.empty", s_empty, 1);
        chk("arst.ae", s_ae, 1);
        chk("arst.af", s_af, 0);
        chk("arst.dout", s_dout, 0);
        chk("arst.fwft_count", f_count, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b0, 8'h11);
        chk("post_rst.fwft_head", f_dout, 8'h11);
        chk("post_rst.count", s_count, 1);
        step(1'b0, 1'b1, 1'b0, 8'h22);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("post_rst.dout", s_dout, 8'h11);
        chk("post_rst.count_after", s_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO and the next generation of synchronous_fifo. Generalised in width and depth, it adds programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. It is the buffering element used between same-clock producer and consumer blocks.

Parameters:
DATA_WIDTH, 8, width of data_in/data_out
DEPTH, 16, number of entries; power of 2, >= 4 (elaboration error otherwise)
AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH; legal range 1..DEPTH
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH; legal range 0..DEPTH-1
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous flush; priority over w_en/r_en
w_en  in  1  write request
r_en  in  1  read request (FWFT: pop/acknowledge of current head)
data_in  in  DATA_WIDTH  write data
data_out  out  DATA_WIDTH  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (rst_n low, asynchronous): pointers 0, count 0, empty 1, almost_empty 1, full 0, almost_full 0, overflow 0, underflow 0, data_out 0. Memory contents are not reset.
- Pointers are $clog2(DEPTH)+1 bits wide, with the MSB as the wrap bit. count = wr_ptr - rd_ptr (modulo). Index wrap from DEPTH-1 to 0 is natural.
- Write accepted iff w_en && !full: mem[wr_ptr] <= data_in, and wr_ptr increments.
- Read accepted iff r_en && !empty: rd_ptr increments.
- Both requests accepted in the same cycle: count is unchanged.
- When full, w_en && r_en accepts the read only. The write is dropped and overflow is set.
- When empty, w_en && r_en accepts the write only. underflow is set.
- Flags are decoded from registered pointers. They reflect state after the most recent edge, with zero extra latency.
- Standard mode (FWFT=0): on an accepted read, data_out <= mem[rd_ptr] at that edge, so data is valid 1 cycle after r_en is sampled. data_out holds its value otherwise, including on rejected reads.
- FWFT mode (FWFT=1): data_out = mem[rd_ptr] combinationally. It is valid whenever !empty and don't-care when empty. A write to an empty FIFO appears on data_out after that write edge (1-cycle latency). r_en pops the head.
- overflow/underflow: set on the offending edge and held until clr or reset. A simultaneous set and clr resolves to clr.
- clr: at the next edge, pointers go to 0 and both sticky flags clear. Standard mode also forces data_out to 0. Concurrent w_en/r_en are ignored and raise no error flag.
- Reset asserted mid-operation: immediate return to reset state. Data already in flight is lost.

Decomposition:
- Package sync_fifo_pkg: function ptr_w(depth) = $clog2(depth)+1, and the FWFT mode constants (MODE_STD=0, MODE_FWFT=1).
- One sub-module, fifo_mem: DATA_WIDTH x DEPTH register array, one synchronous write port and one asynchronous read port.
- Pointer, flag and output logic stays in sync_fifo_param.

Test Plan:
- Reset, then 16 writes 0x01..0x10 (DEPTH=16) -> count 16, full 1, almost_full from count 14. A 17th write is dropped with overflow 1. Sixteen reads return 0x01..0x10 in order, each 1 cycle after r_en, ending with empty 1.
- Alternate write/read for 40 cycles of random data -> pointers wrap twice, a scoreboard matches every word, and count never exceeds 1.
- Full FIFO with w_en=r_en=1 for 1 cycle -> head word read, write dropped, count 15, overflow 1. Empty FIFO with w_en=r_en=1 and data 0xA5 -> count 1, underflow 1, next read returns 0xA5.
- FWFT=1: write 0x3C into an empty FIFO -> data_out 0x3C the cycle after the write with r_en low. A pop with a second word 0x4D queued -> data_out 0x4D the next cycle.
- Fill to 10, set both sticky flags, pulse clr alongside w_en=1 -> next cycle count 0, empty 1, overflow 0, underflow 0, no write occurred.
- Drop rst_n mid-burst at count 7, asynchronously between edges -> all outputs reach reset values before the next clk edge. After release, writes resume from pointer 0.
